multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RV32I-style control unit: sequences FETCH / EXECUTE / MEM /
// PC_UPDATE / TRAP, decodes instruction fields into datapath controls,
// bounds memory waits with a timeout, and counts retired instructions.

module multicycle_controller #(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [XLEN-1:0]   immediate,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   memory_read_value,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic [3:0]        pc_control,
    output logic [1:0]        ir_control,
    output logic [3:0]        alu_control,
    output logic [XLEN-1:0]   op2,
    output logic              register_write_en,
    output logic [XLEN-1:0]   register_file_write,
    output logic              mem_req,
    output logic              memory_write_en,
    output logic [XLEN-1:0]   memory_address,
    output logic [XLEN-1:0]   memory_write,
    output logic [2:0]        memory_funct3,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired_count
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [3:0] PC_HOLD     = 4'b0000;
    localparam logic [3:0] PC_PLUS4    = 4'b0100;
    localparam logic [3:0] PC_PLUS_IMM = 4'b0110;
    localparam logic [3:0] PC_RS1_IMM  = 4'b0101;
    localparam logic [3:0] PC_TRAP_VEC = 4'b0111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Wide enough to hold MEM_TIMEOUT itself.
    localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        EXECUTE   = 3'd1,
        MEM       = 3'd2,
        PC_UPDATE = 3'd3,
        TRAP      = 3'd4
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [1:0]          cause_q;
    logic [1:0]          cause_d;
    logic [CNT_W-1:0]    retired_q;
    logic [3:0]          alu_op_dec;
    logic                illegal;
    logic [XLEN-1:0]     load_value;
    logic                wait_expired;
    logic                retire;

    // Decode the ALU operation and flag encodings this core does not implement.
    always_comb begin
        alu_op_dec = ALU_ADD;
        illegal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == FUNCT7_BASE) begin
                    case (funct3)
                        3'b000:  alu_op_dec = ALU_ADD;
                        3'b001:  alu_op_dec = ALU_SLL;
                        3'b010:  alu_op_dec = ALU_SLT;
                        3'b011:  alu_op_dec = ALU_SLTU;
                        3'b100:  alu_op_dec = ALU_XOR;
                        3'b101:  alu_op_dec = ALU_SRL;
                        3'b110:  alu_op_dec = ALU_OR;
                        default: alu_op_dec = ALU_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT) begin
                    if (funct3 == 3'b000) begin
                        alu_op_dec = ALU_SUB;
                    end else if (funct3 == 3'b101) begin
                        alu_op_dec = ALU_SRA;
                    end else begin
                        illegal = 1'b1;
                    end
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IALU: begin
                case (funct3)
                    3'b000: alu_op_dec = ALU_ADD;
                    3'b010: alu_op_dec = ALU_SLT;
                    3'b011: alu_op_dec = ALU_SLTU;
                    3'b100: alu_op_dec = ALU_XOR;
                    3'b110: alu_op_dec = ALU_OR;
                    3'b111: alu_op_dec = ALU_AND;
                    3'b001: begin
                        if (immediate[11:5] == FUNCT7_BASE) begin
                            alu_op_dec = ALU_SLL;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: begin
                        if (immediate[11:5] == FUNCT7_BASE) begin
                            alu_op_dec = ALU_SRL;
                        end else if (immediate[11:5] == FUNCT7_ALT) begin
                            alu_op_dec = ALU_SRA;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end
            OP_LUI, OP_AUIPC, OP_JAL: illegal = 1'b0;
            OP_JALR:   illegal = (funct3 != 3'b000);
            OP_BRANCH: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_LOAD:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_STORE:  illegal = (funct3 > 3'b010);
            default:   illegal = 1'b1;
        endcase
    end

    // Size/sign-adjust the returned memory word according to the load type.
    always_comb begin
        load_value = memory_read_value;
        case (funct3)
            3'b000:  load_value = {{(XLEN-8){memory_read_value[7]}}, memory_read_value[7:0]};
            3'b001:  load_value = {{(XLEN-16){memory_read_value[15]}}, memory_read_value[15:0]};
            3'b100:  load_value = {{(XLEN-8){1'b0}}, memory_read_value[7:0]};
            3'b101:  load_value = {{(XLEN-16){1'b0}}, memory_read_value[15:0]};
            default: load_value = memory_read_value;
        endcase
    end

    assign wait_expired = !mem_ready && (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    // Next-state and output decode; everything stays 0 while reset is held.
    always_comb begin
        state_d             = state_q;
        cause_d             = cause_q;
        pc_control          = PC_HOLD;
        ir_control          = 2'b00;
        alu_control         = ALU_ADD;
        op2                 = '0;
        register_write_en   = 1'b0;
        register_file_write = '0;
        mem_req             = 1'b0;
        memory_write_en     = 1'b0;
        memory_address      = '0;
        memory_write        = '0;
        memory_funct3       = 3'b000;
        trap                = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req        = 1'b1;
                    memory_address = pc;
                    memory_funct3  = 3'b010;
                    if (mem_ready) begin
                        ir_control = 2'b01;
                        state_d    = EXECUTE;
                    end else if (wait_expired) begin
                        state_d = TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
                EXECUTE: begin
                    if (illegal) begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        case (opcode)
                            OP_RTYPE: begin
                                alu_control         = alu_op_dec;
                                op2                 = rs2;
                                register_write_en   = 1'b1;
                                register_file_write = alu_result;
                                state_d             = PC_UPDATE;
                            end
                            OP_IALU: begin
                                alu_control         = alu_op_dec;
                                op2                 = immediate;
                                register_write_en   = 1'b1;
                                register_file_write = alu_result;
                                state_d             = PC_UPDATE;
                            end
                            OP_LUI: begin
                                register_write_en   = 1'b1;
                                register_file_write = immediate;
                                state_d             = PC_UPDATE;
                            end
                            OP_AUIPC: begin
                                register_write_en   = 1'b1;
                                register_file_write = pc + immediate;
                                state_d             = PC_UPDATE;
                            end
                            OP_JAL: begin
                                pc_control          = PC_PLUS_IMM;
                                register_write_en   = 1'b1;
                                register_file_write = pc + XLEN'(4);
                                state_d             = FETCH;
                            end
                            OP_JALR: begin
                                pc_control          = PC_RS1_IMM;
                                register_write_en   = 1'b1;
                                register_file_write = pc + XLEN'(4);
                                state_d             = FETCH;
                            end
                            OP_BRANCH: begin
                                if (branch_taken) begin
                                    pc_control = PC_PLUS_IMM;
                                    state_d    = FETCH;
                                end else begin
                                    state_d = PC_UPDATE;
                                end
                            end
                            OP_LOAD, OP_STORE: begin
                                alu_control = ALU_ADD;
                                op2         = immediate;
                                state_d     = MEM;
                            end
                            default: begin
                                state_d = TRAP;
                                cause_d = CAUSE_ILLEGAL;
                            end
                        endcase
                    end
                end
                MEM: begin
                    mem_req        = 1'b1;
                    memory_address = alu_result;
                    memory_funct3  = funct3;
                    op2            = immediate;
                    if (opcode == OP_STORE) begin
                        memory_write_en = 1'b1;
                        memory_write    = rs2;
                    end
                    if (mem_ready) begin
                        if (opcode != OP_STORE) begin
                            register_write_en   = 1'b1;
                            register_file_write = load_value;
                        end
                        state_d = PC_UPDATE;
                    end else if (wait_expired) begin
                        state_d = TRAP;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
                PC_UPDATE: begin
                    pc_control = PC_PLUS4;
                    state_d    = FETCH;
                end
                TRAP: begin
                    trap       = 1'b1;
                    pc_control = PC_TRAP_VEC;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign retire = (state_q == PC_UPDATE) || ((state_q == EXECUTE) && (state_d == FETCH));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory wait counter: counts stalled cycles while a request is pending, clears otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state_q == FETCH || state_q == MEM) && (state_d == state_q) && !mem_ready) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Trap cause is captured on the way into TRAP and held until the next trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q <= CAUSE_NONE;
        end else if ((state_d == TRAP) && (state_q != TRAP)) begin
            cause_q <= cause_d;
        end
    end

    // Retired-instruction counter, wrapping naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state         = state_q;
    assign trap_cause    = cause_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.

module tb_multicycle_controller;

    localparam int XLEN = 32;
    localparam int CNT_W = 32;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_PCUPD = 3'd3;
    localparam logic [2:0] S_TRAP  = 3'd4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [6:0]        opcode = '0;
    logic [2:0]        funct3 = '0;
    logic [6:0]        funct7 = '0;
    logic [XLEN-1:0]   immediate = '0;
    logic [XLEN-1:0]   pc = '0;
    logic [XLEN-1:0]   rs2 = '0;
    logic [XLEN-1:0]   alu_result = '0;
    logic [XLEN-1:0]   memory_read_value = '0;
    logic              branch_taken = 1'b0;
    logic              mem_ready = 1'b0;
    logic [3:0]        pc_control;
    logic [1:0]        ir_control;
    logic [3:0]        alu_control;
    logic [XLEN-1:0]   op2;
    logic              register_write_en;
    logic [XLEN-1:0]   register_file_write;
    logic              mem_req;
    logic              memory_write_en;
    logic [XLEN-1:0]   memory_address;
    logic [XLEN-1:0]   memory_write;
    logic [2:0]        memory_funct3;
    logic              trap;
    logic [1:0]        trap_cause;
    logic [2:0]        state;
    logic [CNT_W-1:0]  retired_count;

    int n_pass = 0;
    int n_total = 0;

    multicycle_controller #(.XLEN(XLEN), .CNT_W(CNT_W), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .immediate(immediate), .pc(pc), .rs2(rs2), .alu_result(alu_result),
        .memory_read_value(memory_read_value), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .pc_control(pc_control), .ir_control(ir_control),
        .alu_control(alu_control), .op2(op2), .register_write_en(register_write_en),
        .register_file_write(register_file_write), .mem_req(mem_req),
        .memory_write_en(memory_write_en), .memory_address(memory_address),
        .memory_write(memory_write), .memory_funct3(memory_funct3), .trap(trap),
        .trap_cause(trap_cause), .state(state), .retired_count(retired_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One FETCH cycle that completes immediately.
    task automatic fetch_cycle(input logic [XLEN-1:0] pc_val);
        pc = pc_val;
        mem_ready = 1'b1;
        #1;
        check_output("fetch_state", state, S_FETCH);
        check_output("fetch_req", mem_req, 1);
        check_output("fetch_addr", memory_address, pc_val);
        check_output("fetch_ir", ir_control, 2'b01);
        tick();
    endtask

    initial begin
        tick();
        #1;
        check_output("rst_state", state, S_FETCH);
        check_output("rst_req", mem_req, 0);
        check_output("rst_retired", retired_count, 0);
        check_output("rst_cause", trap_cause, 0);
        check_output("rst_pcctl", pc_control, 0);

        // ADD x3: alu_result 12
        reset = 1'b0;
        fetch_cycle(32'h40);
        opcode = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
        rs2 = 32'd5; alu_result = 32'd12;
        #1;
        check_output("add_state", state, S_EXEC);
        check_output("add_we", register_write_en, 1);
        check_output("add_wdata", register_file_write, 32'd12);
        check_output("add_alu", alu_control, 4'b0000);
        check_output("add_op2", op2, 32'd5);
        tick();
        #1;
        check_output("add_pcupd", state, S_PCUPD);
        check_output("add_pcctl", pc_control, 4'b0100);
        check_output("add_ret0", retired_count, 0);
        tick();
        check_output("add_ret1", retired_count, 1);

        // SUB
        fetch_cycle(32'h44);
        funct7 = 7'b0100000;
        #1;
        check_output("sub_alu", alu_control, 4'b0001);
        tick();
        tick();

        // SRAI: shift type comes from immediate[11:5]
        fetch_cycle(32'h48);
        opcode = 7'b0010011; funct3 = 3'b101; funct7 = 7'b0000000; immediate = 32'h403;
        #1;
        check_output("srai_alu", alu_control, 4'b1001);
        check_output("srai_op2", op2, 32'h403);
        tick();
        tick();
        check_output("srai_ret", retired_count, 3);

        // LB with mem_ready delayed 3 cycles
        fetch_cycle(32'h4C);
        opcode = 7'b0000011; funct3 = 3'b000; immediate = 32'd4;
        alu_result = 32'h204; memory_read_value = 32'h80;
        #1;
        check_output("lb_ex_alu", alu_control, 4'b0000);
        check_output("lb_ex_op2", op2, 32'd4);
        check_output("lb_ex_req", mem_req, 0);
        check_output("lb_ex_we", register_write_en, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check_output("lb_wait_state", state, S_MEM);
            check_output("lb_wait_req", mem_req, 1);
            check_output("lb_wait_we", register_write_en, 0);
        end
        tick();
        mem_ready = 1'b1;
        #1;
        check_output("lb_req4", mem_req, 1);
        check_output("lb_addr", memory_address, 32'h204);
        check_output("lb_f3", memory_funct3, 3'b000);
        check_output("lb_we", register_write_en, 1);
        check_output("lb_data", register_file_write, 32'hFFFFFF80);
        tick();
        check_output("lb_pcupd", state, S_PCUPD);
        tick();
        check_output("lb_ret", retired_count, 4);

        // LBU
        fetch_cycle(32'h50);
        funct3 = 3'b100;
        tick();
        #1;
        check_output("lbu_state", state, S_MEM);
        check_output("lbu_data", register_file_write, 32'h00000080);
        tick();
        tick();

        // SW
        fetch_cycle(32'h54);
        opcode = 7'b0100011; funct3 = 3'b010; rs2 = 32'hDEADBEEF; alu_result = 32'h300;
        tick();
        #1;
        check_output("sw_wen", memory_write_en, 1);
        check_output("sw_wdata", memory_write, 32'hDEADBEEF);
        check_output("sw_regwe", register_write_en, 0);
        tick();
        tick();
        check_output("sw_ret", retired_count, 6);

        // BEQ taken at pc 0x100
        fetch_cycle(32'h100);
        opcode = 7'b1100011; funct3 = 3'b000; branch_taken = 1'b1;
        #1;
        check_output("beqt_pcctl", pc_control, 4'b0110);
        check_output("beqt_we", register_write_en, 0);
        tick();
        check_output("beqt_next", state, S_FETCH);
        check_output("beqt_ret", retired_count, 7);

        // BEQ not taken
        fetch_cycle(32'h100);
        branch_taken = 1'b0;
        #1;
        check_output("beqn_pcctl", pc_control, 4'b0000);
        tick();
        check_output("beqn_next", state, S_PCUPD);
        tick();

        // JAL writes pc+4
        fetch_cycle(32'h100);
        opcode = 7'b1101111;
        #1;
        check_output("jal_pcctl", pc_control, 4'b0110);
        check_output("jal_wdata", register_file_write, 32'h104);
        tick();
        check_output("jal_next", state, S_FETCH);
        check_output("jal_ret", retired_count, 9);

        // Illegal opcode
        fetch_cycle(32'h200);
        opcode = 7'b0000000;
        #1;
        check_output("ill_we", register_write_en, 0);
        tick();
        #1;
        check_output("ill_state", state, S_TRAP);
        check_output("ill_trap", trap, 1);
        check_output("ill_cause", trap_cause, 2'b01);
        check_output("ill_pcctl", pc_control, 4'b0111);
        mem_ready = 1'b0;
        tick();
        #1;
        check_output("ill_pulse", trap, 0);
        check_output("ill_cause_hold", trap_cause, 2'b01);
        check_output("ill_ret", retired_count, 9);

        // Fetch timeout: 16 FETCH cycles then TRAP
        for (int i = 0; i < 16; i++) begin
            check_output("to_fetch", state, S_FETCH);
            tick();
            #1;
        end
        check_output("to_state", state, S_TRAP);
        check_output("to_cause", trap_cause, 2'b10);
        check_output("to_ret", retired_count, 9);
        tick();

        // Reset asserted in the middle of a MEM cycle
        fetch_cycle(32'h300);
        opcode = 7'b0000011; funct3 = 3'b010;
        mem_ready = 1'b0;
        tick();
        #1;
        check_output("rm_req_before", mem_req, 1);
        reset = 1'b1;
        #1;
        check_output("rm_req", mem_req, 0);
        check_output("rm_state", state, S_FETCH);
        check_output("rm_ret", retired_count, 0);
        check_output("rm_cause", trap_cause, 0);
        tick();
        reset = 1'b0;
        fetch_cycle(32'h0);
        check_output("rm_exec", state, S_EXEC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
